alu_decode_exec: RTL and testbench
==================================

ALU_DECODE_EXEC -- requirements
Module: alu_decode_exec

Interface
REQ-001 clk  input  1  sole clock; all state on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 opcode/funct3/funct7  input  7/3/7  instruction fields.
REQ-004 rs1_val/rs2_val/imm/pc  input  32 each  operands, sign-extended immediate, current PC.
REQ-005 reg_write, alu_src, mem_read, mem_write, mem_to_reg, branch, jump, jump_r, csr_read_en, csr_write_en, is_csr  output  1 each  combinational control.
REQ-006 branch_type  output  3  000 BEQ, 001 BNE, 010 BLT, 011 BGE, 100 BLTU, 101 BGEU.
REQ-007 alu_op  output  2  00 add, 01 compare/sub, 10 R-type, 11 I-type.
REQ-008 alu_ctrl  output  5  resolved ALU operation code.
REQ-009 alu_result  output  32  combinational result; zero  output  1  alu_result==0.
REQ-010 branch_taken  output  1; next_pc  output  32.
REQ-011 result_q  output  32  registered alu_result; illegal_q  output  1  sticky illegal-instruction flag.

Function
REQ-012 Decode opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011, SYSTEM 1110011.
REQ-013 reg_write=1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, CSR; alu_src=1 for all except OP and BRANCH.
REQ-014 LOAD: mem_read=1, mem_to_reg=1; STORE: mem_write=1, reg_write=0.
REQ-015 SYSTEM with funct3!=000: is_csr=1, csr_read_en=1, csr_write_en=1 only for funct3 001/010/011.
REQ-016 Unknown opcode or SYSTEM funct3=000: all controls 0, alu_ctrl=ADD, instruction illegal.
REQ-017 ALU ops: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT (signed), SLTU, PASSB; shifts use B[4:0].
REQ-018 OP-IMM: funct3 maps as OP, but SUB never selected; SRAI when funct7[5]=1 with funct3 101.
REQ-019 OP with funct7 0100000: SUB (000) / SRA (101); other funct7 values outside REQ-031 illegal.
REQ-020 Operand A = pc for AUIPC/JAL/JALR, else rs1_val; operand B = 4 for JAL/JALR, imm if alu_src, else rs2_val.
REQ-021 LUI -> PASSB (result=imm); JAL/JALR result = pc+4 (link).
REQ-022 BRANCH uses alu_op 01, alu_ctrl SUB; taken: BEQ eq, BNE ne, BLT/BGE signed, BLTU/BGEU unsigned compare of rs1_val,rs2_val; funct3 010/011 illegal.
REQ-023 next_pc: JALR (rs1_val+imm)&~1; JAL pc+imm; taken branch pc+imm; else pc+4; 32-bit wrap-around.
REQ-024 All arithmetic modulo 2^32; no overflow flag.

Reset
REQ-025 rst_n low: result_q=0, illegal_q=0 immediately.
REQ-026 Out of reset: result_q<=alu_result every cycle.
REQ-027 illegal_q sets on any clock edge with illegal decode; clears only by reset.
REQ-028 Combinational outputs independent of reset.

Configuration
REQ-029 Macro ALU_M_EXT_EN enables RV32M.
REQ-030 Without it: OP with funct7 0000001 illegal, alu_result=0.
REQ-031 With it: OP funct7 0000001, funct3 000-111 = MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU, single-cycle.
REQ-032 Divide by zero: DIV/DIVU = 0xFFFFFFFF, REM/REMU = dividend; DIV 0x80000000/-1 = 0x80000000, REM = 0.

Verification
REQ-033 OP ADD 5+0xFFFFFFFF -> alu_result 4, zero 0, reg_write 1; next edge result_q=4.
REQ-034 BLT rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=0x20 -> branch_taken 1, next_pc 0x120; BLTU same operands -> next_pc 0x104.
REQ-035 JALR rs1=0x1001, imm=2, pc=0x40 -> next_pc 0x1002, alu_result 0x44, jump_r 1.
REQ-036 With ALU_M_EXT_EN: MUL 0x17*0x8 -> 0xB8; DIV 7/0 -> 0xFFFFFFFF; REM 0x80000000 % -1 -> 0.
REQ-037 opcode 0000000 -> all controls 0, illegal_q 1 after edge, persists; rst_n low clears asynchronously.
REQ-038 Without ALU_M_EXT_EN: MUL encoding -> alu_result 0, illegal_q 1.

Source files
------------

// File: rtl/alu_decode_exec.sv
// Single-cycle RV32I decode + ALU + next-PC unit with registered result and sticky illegal flag.
// Optional RV32M multiply/divide enabled by defining ALU_M_EXT_EN.
module alu_decode_exec (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    input  logic [31:0] imm,
    input  logic [31:0] pc,
    output logic        reg_write,
    output logic        alu_src,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_to_reg,
    output logic        branch,
    output logic        jump,
    output logic        jump_r,
    output logic        csr_read_en,
    output logic        csr_write_en,
    output logic        is_csr,
    output logic [2:0]  branch_type,
    output logic [1:0]  alu_op,
    output logic [4:0]  alu_ctrl,
    output logic [31:0] alu_result,
    output logic        zero,
    output logic        branch_taken,
    output logic [31:0] next_pc,
    output logic [31:0] result_q,
    output logic        illegal_q
);

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OP_IMM = 7'b0010011,
        OPC_OP     = 7'b0110011,
        OPC_SYSTEM = 7'b1110011
    } opcode_e;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
        ALU_SLT, ALU_SLTU, ALU_PASSB,
        ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
    } alu_ctrl_e;

    alu_ctrl_e   ctrl;
    logic        illegal;
    logic        kill_result;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] alu_raw;
    logic [4:0]  shamt;

    function automatic alu_ctrl_e base_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // Controls are only raised once an encoding is known to be legal, so
    // every illegal path leaves them at their all-zero defaults.
    always_comb begin
        reg_write    = 1'b0;
        alu_src      = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_to_reg   = 1'b0;
        branch       = 1'b0;
        jump         = 1'b0;
        jump_r       = 1'b0;
        csr_read_en  = 1'b0;
        csr_write_en = 1'b0;
        is_csr       = 1'b0;
        branch_type  = 3'b000;
        alu_op       = 2'b00;
        ctrl         = ALU_ADD;
        illegal      = 1'b0;
        kill_result  = 1'b0;
        case (opcode)
            OPC_LUI: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                ctrl      = ALU_PASSB;
            end
            OPC_AUIPC: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
            end
            OPC_JAL: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                jump      = 1'b1;
            end
            OPC_JALR: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                jump_r    = 1'b1;
            end
            OPC_BRANCH: begin
                case (funct3)
                    3'b000:  branch_type = 3'b000;
                    3'b001:  branch_type = 3'b001;
                    3'b100:  branch_type = 3'b010;
                    3'b101:  branch_type = 3'b011;
                    3'b110:  branch_type = 3'b100;
                    3'b111:  branch_type = 3'b101;
                    default: illegal     = 1'b1;
                endcase
                if (!illegal) begin
                    branch = 1'b1;
                    alu_op = 2'b01;
                    ctrl   = ALU_SUB;
                end
            end
            OPC_LOAD: begin
                reg_write  = 1'b1;
                alu_src    = 1'b1;
                mem_read   = 1'b1;
                mem_to_reg = 1'b1;
            end
            OPC_STORE: begin
                alu_src   = 1'b1;
                mem_write = 1'b1;
            end
            OPC_OP_IMM: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                alu_op    = 2'b11;
                ctrl      = base_op(funct3, funct7[5]);
            end
            OPC_OP: begin
                if (funct7 == 7'b0000000) begin
                    reg_write = 1'b1;
                    alu_op    = 2'b10;
                    ctrl      = base_op(funct3, 1'b0);
                end else if (funct7 == 7'b0100000 &&
                             (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    reg_write = 1'b1;
                    alu_op    = 2'b10;
                    ctrl      = (funct3 == 3'b000) ? ALU_SUB : ALU_SRA;
                end else if (funct7 == 7'b0000001) begin
`ifdef ALU_M_EXT_EN
                    reg_write = 1'b1;
                    alu_op    = 2'b10;
                    ctrl      = alu_ctrl_e'(5'(ALU_MUL) + 5'(funct3));
`else
                    illegal     = 1'b1;
                    kill_result = 1'b1;
`endif
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_SYSTEM: begin
                if (funct3 == 3'b000) begin
                    illegal = 1'b1;
                end else begin
                    reg_write    = 1'b1;
                    alu_src      = 1'b1;
                    is_csr       = 1'b1;
                    csr_read_en  = 1'b1;
                    csr_write_en = ~funct3[2];
                end
            end
            default: illegal = 1'b1;
        endcase
    end

    assign alu_ctrl = ctrl;
    assign op_a  = (opcode == OPC_AUIPC || opcode == OPC_JAL || opcode == OPC_JALR) ? pc : rs1_val;
    assign op_b  = (jump || jump_r) ? 32'd4 : (alu_src ? imm : rs2_val);
    assign shamt = op_b[4:0];

`ifdef ALU_M_EXT_EN
    logic        a_sgn;
    logic        b_sgn;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] prod;
    logic        div_zero;
    logic        div_ovf;

    // One 64x64 multiplier serves all four variants; the low half is
    // sign-agnostic and the high half depends only on operand extension.
    assign a_sgn    = (ctrl == ALU_MULH) || (ctrl == ALU_MULHSU);
    assign b_sgn    = (ctrl == ALU_MULH);
    assign mul_a    = {{32{a_sgn & op_a[31]}}, op_a};
    assign mul_b    = {{32{b_sgn & op_b[31]}}, op_b};
    assign prod     = mul_a * mul_b;
    assign div_zero = (op_b == '0);
    assign div_ovf  = (op_a == 32'h8000_0000) && (op_b == '1);
`endif

    always_comb begin
        alu_raw = '0;
        case (ctrl)
            ALU_ADD:   alu_raw = op_a + op_b;
            ALU_SUB:   alu_raw = op_a - op_b;
            ALU_AND:   alu_raw = op_a & op_b;
            ALU_OR:    alu_raw = op_a | op_b;
            ALU_XOR:   alu_raw = op_a ^ op_b;
            ALU_SLL:   alu_raw = op_a << shamt;
            ALU_SRL:   alu_raw = op_a >> shamt;
            ALU_SRA:   alu_raw = $signed(op_a) >>> shamt;
            ALU_SLT:   alu_raw = {31'b0, $signed(op_a) < $signed(op_b)};
            ALU_SLTU:  alu_raw = {31'b0, op_a < op_b};
            ALU_PASSB: alu_raw = op_b;
`ifdef ALU_M_EXT_EN
            ALU_MUL:    alu_raw = prod[31:0];
            ALU_MULH,
            ALU_MULHSU,
            ALU_MULHU:  alu_raw = prod[63:32];
            ALU_DIV:    alu_raw = div_zero ? '1 : (div_ovf ? 32'h8000_0000 : $signed(op_a) / $signed(op_b));
            ALU_DIVU:   alu_raw = div_zero ? '1 : op_a / op_b;
            ALU_REM:    alu_raw = div_zero ? op_a : (div_ovf ? '0 : $signed(op_a) % $signed(op_b));
            ALU_REMU:   alu_raw = div_zero ? op_a : op_a % op_b;
`endif
            default:   alu_raw = '0;
        endcase
    end

    assign alu_result = kill_result ? '0 : alu_raw;
    assign zero       = (alu_result == '0);

    always_comb begin
        branch_taken = 1'b0;
        if (branch) begin
            case (branch_type)
                3'b000:  branch_taken = (rs1_val == rs2_val);
                3'b001:  branch_taken = (rs1_val != rs2_val);
                3'b010:  branch_taken = ($signed(rs1_val) <  $signed(rs2_val));
                3'b011:  branch_taken = ($signed(rs1_val) >= $signed(rs2_val));
                3'b100:  branch_taken = (rs1_val <  rs2_val);
                3'b101:  branch_taken = (rs1_val >= rs2_val);
                default: branch_taken = 1'b0;
            endcase
        end
    end

    always_comb begin
        if (jump_r)
            next_pc = (rs1_val + imm) & ~32'h1;
        else if (jump || branch_taken)
            next_pc = pc + imm;
        else
            next_pc = pc + 32'd4;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            result_q <= alu_result;
            if (illegal)
                illegal_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_decode_exec.sv
// Directed, table-driven bench for alu_decode_exec; adapts expectations to ALU_M_EXT_EN.
module tb_alu_decode_exec;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] rs1_val, rs2_val, imm, pc;
    logic        reg_write, alu_src, mem_read, mem_write, mem_to_reg, branch, jump, jump_r;
    logic        csr_read_en, csr_write_en, is_csr;
    logic [2:0]  branch_type;
    logic [1:0]  alu_op;
    logic [4:0]  alu_ctrl;
    logic [31:0] alu_result, next_pc, result_q;
    logic        zero, branch_taken, illegal_q;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    alu_decode_exec dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm), .pc(pc),
        .reg_write(reg_write), .alu_src(alu_src), .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .branch(branch), .jump(jump), .jump_r(jump_r),
        .csr_read_en(csr_read_en), .csr_write_en(csr_write_en), .is_csr(is_csr),
        .branch_type(branch_type), .alu_op(alu_op), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .zero(zero), .branch_taken(branch_taken),
        .next_pc(next_pc), .result_q(result_q), .illegal_q(illegal_q)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111,
                           JALR = 7'b1100111, BR = 7'b1100011, LD = 7'b0000011,
                           ST = 7'b0100011, OPI = 7'b0010011, OP = 7'b0110011,
                           SYS = 7'b1110011;

    // Control bundle bit positions, matching the concatenation in ctrl_now.
    localparam logic [10:0] C_RW  = 11'b100_0000_0000, C_SRC = 11'b010_0000_0000,
                            C_MR  = 11'b001_0000_0000, C_MW  = 11'b000_1000_0000,
                            C_MTR = 11'b000_0100_0000, C_BR  = 11'b000_0010_0000,
                            C_J   = 11'b000_0001_0000, C_JR  = 11'b000_0000_1000,
                            C_CR  = 11'b000_0000_0100, C_CW  = 11'b000_0000_0010,
                            C_CSR = 11'b000_0000_0001;

    typedef struct {
        string       name;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] rs1, rs2, imm, pc;
        logic [31:0] res;
        logic        chk_res;
        logic [10:0] ctrl;
        logic [1:0]  aop;
        logic [2:0]  bt;
        logic        taken;
        logic [31:0] npc;
        logic        ill;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(string n, logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
                                logic [31:0] rs1, logic [31:0] rs2, logic [31:0] im,
                                logic [31:0] p, logic [31:0] res, logic cr,
                                logic [10:0] ctl, logic [1:0] aop, logic [2:0] bt,
                                logic tk, logic [31:0] npc, logic ill);
        vec_t v;
        v.name = n; v.op = op; v.f3 = f3; v.f7 = f7; v.rs1 = rs1; v.rs2 = rs2;
        v.imm = im; v.pc = p; v.res = res; v.chk_res = cr; v.ctrl = ctl; v.aop = aop;
        v.bt = bt; v.taken = tk; v.npc = npc; v.ill = ill;
        vecs.push_back(v);
    endfunction

    function automatic logic [10:0] ctrl_now();
        return {reg_write, alu_src, mem_read, mem_write, mem_to_reg, branch, jump, jump_r,
                csr_read_en, csr_write_en, is_csr};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
                         logic [31:0] a, logic [31:0] b, logic [31:0] im, logic [31:0] p);
        opcode = op; funct3 = f3; funct7 = f7; rs1_val = a; rs2_val = b; imm = im; pc = p;
    endtask

    task automatic run_vec(vec_t v);
        @(negedge clk);
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        drive(v.op, v.f3, v.f7, v.rs1, v.rs2, v.imm, v.pc);
        #1;
        if (v.chk_res) begin
            chk({v.name, ".alu_result"}, alu_result, v.res);
            chk({v.name, ".zero"}, 32'(zero), 32'(v.res == 32'h0));
        end
        chk({v.name, ".ctrl"}, 32'(ctrl_now()), 32'(v.ctrl));
        chk({v.name, ".alu_op"}, 32'(alu_op), 32'(v.aop));
        if (v.ctrl[5])
            chk({v.name, ".branch_type"}, 32'(branch_type), 32'(v.bt));
        chk({v.name, ".branch_taken"}, 32'(branch_taken), 32'(v.taken));
        chk({v.name, ".next_pc"}, next_pc, v.npc);
        @(posedge clk);
        #1;
        if (v.chk_res)
            chk({v.name, ".result_q"}, result_q, v.res);
        chk({v.name, ".illegal_q"}, 32'(illegal_q), 32'(v.ill));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        //   name       op   f3      f7          rs1           rs2           imm           pc            res        cr ctrl               aop    bt      tk npc           ill
        add("add",      OP,  3'b000, 7'b0000000, 32'h5,        32'hFFFFFFFF, 32'h0,        32'h0,        32'h4,        1, C_RW,             2'b10, 3'd0, 0, 32'h4,        0);
        add("sub",      OP,  3'b000, 7'b0100000, 32'h3,        32'h5,        32'h0,        32'h10,       32'hFFFFFFFE, 1, C_RW,             2'b10, 3'd0, 0, 32'h14,       0);
        add("sra",      OP,  3'b101, 7'b0100000, 32'h80000000, 32'h4,        32'h0,        32'h0,        32'hF8000000, 1, C_RW,             2'b10, 3'd0, 0, 32'h4,        0);
        add("srl",      OP,  3'b101, 7'b0000000, 32'h80000000, 32'h24,       32'h0,        32'h0,        32'h08000000, 1, C_RW,             2'b10, 3'd0, 0, 32'h4,        0);
        add("slt",      OP,  3'b010, 7'b0000000, 32'hFFFFFFFF, 32'h1,        32'h0,        32'h0,        32'h1,        1, C_RW,             2'b10, 3'd0, 0, 32'h4,        0);
        add("sltu",     OP,  3'b011, 7'b0000000, 32'hFFFFFFFF, 32'h1,        32'h0,        32'h0,        32'h0,        1, C_RW,             2'b10, 3'd0, 0, 32'h4,        0);
        add("op_bad",   OP,  3'b111, 7'b0100000, 32'h1,        32'h2,        32'h0,        32'h0,        32'h3,        1, 11'h0,            2'b00, 3'd0, 0, 32'h4,        1);
        add("xori",     OPI, 3'b100, 7'b1111111, 32'h0F0F0F0F, 32'h0,        32'hFFFFFFFF, 32'h0,        32'hF0F0F0F0, 1, C_RW|C_SRC,       2'b11, 3'd0, 0, 32'h4,        0);
        add("srai",     OPI, 3'b101, 7'b0100000, 32'hF0000000, 32'h0,        32'h404,      32'h0,        32'hFF000000, 1, C_RW|C_SRC,       2'b11, 3'd0, 0, 32'h4,        0);
        add("addi_f7",  OPI, 3'b000, 7'b0100000, 32'h10,       32'h0,        32'hFFFFFFF0, 32'h0,        32'h0,        1, C_RW|C_SRC,       2'b11, 3'd0, 0, 32'h4,        0);
        add("lui",      LUI, 3'b000, 7'b0000000, 32'h7,        32'h0,        32'h12345000, 32'h200,      32'h12345000, 1, C_RW|C_SRC,       2'b00, 3'd0, 0, 32'h204,      0);
        add("auipc",    AUIPC,3'b000,7'b0000000, 32'h7,        32'h0,        32'h2000,     32'h1000,     32'h3000,     1, C_RW|C_SRC,       2'b00, 3'd0, 0, 32'h1004,     0);
        add("jal",      JAL, 3'b000, 7'b0000000, 32'h7,        32'h0,        32'h80,       32'h100,      32'h104,      1, C_RW|C_SRC|C_J,   2'b00, 3'd0, 0, 32'h180,      0);
        add("jalr",     JALR,3'b000, 7'b0000000, 32'h1001,     32'h0,        32'h2,        32'h40,       32'h44,       1, C_RW|C_SRC|C_JR,  2'b00, 3'd0, 0, 32'h1002,     0);
        add("load",     LD,  3'b010, 7'b0000000, 32'h1000,     32'h0,        32'hFFFFFFFC, 32'h0,        32'hFFC,      1, C_RW|C_SRC|C_MR|C_MTR, 2'b00, 3'd0, 0, 32'h4,   0);
        add("store",    ST,  3'b010, 7'b0000000, 32'h20,       32'h99,       32'h8,        32'h0,        32'h28,       1, C_SRC|C_MW,       2'b00, 3'd0, 0, 32'h4,        0);
        add("blt",      BR,  3'b100, 7'b0000000, 32'hFFFFFFFF, 32'h1,        32'h20,       32'h100,      32'hFFFFFFFE, 1, C_BR,             2'b01, 3'd2, 1, 32'h120,      0);
        add("bltu",     BR,  3'b110, 7'b0000000, 32'hFFFFFFFF, 32'h1,        32'h20,       32'h100,      32'hFFFFFFFE, 1, C_BR,             2'b01, 3'd4, 0, 32'h104,      0);
        add("beq_wrap", BR,  3'b000, 7'b0000000, 32'h7,        32'h7,        32'h20,       32'hFFFFFFF0, 32'h0,        1, C_BR,             2'b01, 3'd0, 1, 32'h10,       0);
        add("bne",      BR,  3'b001, 7'b0000000, 32'h7,        32'h7,        32'h20,       32'h300,      32'h0,        1, C_BR,             2'b01, 3'd1, 0, 32'h304,      0);
        add("bge",      BR,  3'b101, 7'b0000000, 32'h1,        32'hFFFFFFFF, 32'hFFFFFFF0, 32'h400,      32'h2,        1, C_BR,             2'b01, 3'd3, 1, 32'h3F0,      0);
        add("bgeu",     BR,  3'b111, 7'b0000000, 32'h1,        32'hFFFFFFFF, 32'hFFFFFFF0, 32'h400,      32'h2,        1, C_BR,             2'b01, 3'd5, 0, 32'h404,      0);
        add("br_bad",   BR,  3'b010, 7'b0000000, 32'h1,        32'h1,        32'h40,       32'h100,      32'h2,        1, 11'h0,            2'b00, 3'd0, 0, 32'h104,      1);
        add("csrrw",    SYS, 3'b001, 7'b0000000, 32'h55,       32'h0,        32'h0,        32'h0,        32'h0,        0, C_RW|C_SRC|C_CR|C_CW|C_CSR, 2'b00, 3'd0, 0, 32'h4, 0);
        add("csrrsi",   SYS, 3'b110, 7'b0000000, 32'h55,       32'h0,        32'h0,        32'h0,        32'h0,        0, C_RW|C_SRC|C_CR|C_CSR, 2'b00, 3'd0, 0, 32'h4,   0);
        add("ecall",    SYS, 3'b000, 7'b0000000, 32'h1,        32'h2,        32'h0,        32'h0,        32'h3,        1, 11'h0,            2'b00, 3'd0, 0, 32'h4,        1);
        add("opc_zero", 7'b0000000, 3'b000, 7'b0000000, 32'h4, 32'h5,        32'h0,        32'h0,        32'h9,        1, 11'h0,            2'b00, 3'd0, 0, 32'h4,        1);
`ifdef ALU_M_EXT_EN
        add("mul",      OP,  3'b000, 7'b0000001, 32'h17,       32'h8,        32'h0,        32'h0,        32'hB8,       1, C_RW,             2'b10, 3'd0, 0, 32'h4,        0);
        add("mulh",     OP,  3'b001, 7'b0000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h0,        32'h0,        1, C_RW,             2'b10, 3'd0, 0, 32'h4,        0);
        add("mulhsu",   OP,  3'b010, 7'b0000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h0,        32'hFFFFFFFF, 1, C_RW,             2'b10, 3'd0, 0, 32'h4,        0);
        add("mulhu",    OP,  3'b011, 7'b0000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h0,        32'hFFFFFFFE, 1, C_RW,             2'b10, 3'd0, 0, 32'h4,        0);
        add("div_by0",  OP,  3'b100, 7'b0000001, 32'h7,        32'h0,        32'h0,        32'h0,        32'hFFFFFFFF, 1, C_RW,             2'b10, 3'd0, 0, 32'h4,        0);
        add("divu_by0", OP,  3'b101, 7'b0000001, 32'h7,        32'h0,        32'h0,        32'h0,        32'hFFFFFFFF, 1, C_RW,             2'b10, 3'd0, 0, 32'h4,        0);
        add("rem_ovf",  OP,  3'b110, 7'b0000001, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h0,        32'h0,        1, C_RW,             2'b10, 3'd0, 0, 32'h4,        0);
        add("remu_by0", OP,  3'b111, 7'b0000001, 32'h7,        32'h0,        32'h0,        32'h0,        32'h7,        1, C_RW,             2'b10, 3'd0, 0, 32'h4,        0);
        add("rem_by0",  OP,  3'b110, 7'b0000001, 32'h7,        32'h0,        32'h0,        32'h0,        32'h7,        1, C_RW,             2'b10, 3'd0, 0, 32'h4,        0);
        add("div_ovf",  OP,  3'b100, 7'b0000001, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h0,        32'h80000000, 1, C_RW,             2'b10, 3'd0, 0, 32'h4,        0);
        add("div_neg",  OP,  3'b100, 7'b0000001, 32'hFFFFFFF9, 32'h2,        32'h0,        32'h0,        32'hFFFFFFFD, 1, C_RW,             2'b10, 3'd0, 0, 32'h4,        0);
        add("rem_neg",  OP,  3'b110, 7'b0000001, 32'hFFFFFFF9, 32'h2,        32'h0,        32'h0,        32'hFFFFFFFF, 1, C_RW,             2'b10, 3'd0, 0, 32'h4,        0);
`else
        add("mul_off",  OP,  3'b000, 7'b0000001, 32'h17,       32'h8,        32'h0,        32'h0,        32'h0,        1, 11'h0,            2'b00, 3'd0, 0, 32'h4,        1);
        add("div_off",  OP,  3'b100, 7'b0000001, 32'h7,        32'h3,        32'h0,        32'h0,        32'h0,        1, 11'h0,            2'b00, 3'd0, 0, 32'h4,        1);
`endif

        // Reset state, including across a clock edge held in reset.
        rst_n = 1'b0;
        drive(OP, 3'b000, 7'b0, 32'h1, 32'h2, 32'h0, 32'h0);
        #2;
        chk("reset.result_q", result_q, 32'h0);
        chk("reset.illegal_q", 32'(illegal_q), 32'h0);
        @(posedge clk); #1;
        chk("reset_edge.result_q", result_q, 32'h0);
        chk("reset_edge.illegal_q", 32'(illegal_q), 32'h0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // result_q is a register: it holds until the next edge, then follows.
        @(negedge clk);
        rst_n = 1'b0; #1 rst_n = 1'b1;
        drive(OP, 3'b000, 7'b0, 32'h1, 32'h1, 32'h0, 32'h0);
        @(posedge clk); #1;
        chk("pipe.first", result_q, 32'h2);
        drive(OP, 3'b000, 7'b0100000, 32'h10, 32'h1, 32'h0, 32'h0);
        #2;
        chk("pipe.hold", result_q, 32'h2);
        @(posedge clk); #1;
        chk("pipe.second", result_q, 32'hF);

        // Sticky illegal flag survives legal traffic and clears asynchronously.
        drive(7'b0000000, 3'b000, 7'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        @(posedge clk); #1;
        chk("sticky.set", 32'(illegal_q), 32'h1);
        drive(OP, 3'b000, 7'b0, 32'h1, 32'h2, 32'h0, 32'h0);
        for (int unsigned k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("sticky.hold", 32'(illegal_q), 32'h1);
            chk("sticky.result_q", result_q, 32'h3);
        end
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst.illegal_q", 32'(illegal_q), 32'h0);
        chk("async_rst.result_q", result_q, 32'h0);
        chk("async_rst.comb", alu_result, 32'h3);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst.illegal_q", 32'(illegal_q), 32'h0);
        chk("post_rst.result_q", result_q, 32'h3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
